vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be:
- HM 640: active pixels per line
- H_DER 16: horizontal front porch
- H_RETRAZ 96: horizontal sync width
- H_IZQ 48: horizontal back porch
- VM 480: active lines
- V_SUP 10: vertical front porch
- V_RETRAZ 2: vertical sync width
- V_INF 33: vertical back porch
- LOCK_FRAMES 2: clean frames needed to lock
REQ-002 Ports SHALL be:
- CLK input 1: single clock; all logic is on the rising edge.
- RESET input 1: asynchronous, active-low reset.
- p_tick input 1: pixel enable, high for one CLK cycle per pixel.
- sincro_horiz input 1: active-low horizontal sync.
- sincro_vert input 1: active-low vertical sync.
- pixel_X output 10: recovered column.
- pixel_Y output 10: recovered row.
- video_on output 1: active-area flag.
- locked output 1: timing lock flag.
- frame_start output 1: one-CLK pulse at frame origin.
- err_cnt output 8: saturating error count.

Function
REQ-003 All state SHALL advance only on CLK edges where p_tick=1; at every other edge all state SHALL hold.
REQ-004 The block SHALL keep sampled copies hs_q and vs_q, updated each tick; a falling edge is a tick with the sampled register at 1 and the input at 0.
REQ-005 pixel_X SHALL increment per tick, wrap 799->0, and load 656 (HM+H_DER) on an hsync falling edge; the load takes priority over the increment and the wrap.
REQ-006 pixel_Y SHALL increment when pixel_X wraps 799->0, wrap 524->0, and load 490 (VM+V_SUP) on a vsync falling edge; the load takes priority.
REQ-007 When hsync and vsync falling edges occur on the same tick, both loads SHALL apply on that tick.
REQ-008 Line-length counter len_h (10 bit) SHALL:
- count ticks between hsync falling edges and saturate at 1023;
- compare against 800 at each hsync edge, then restart at 1.
REQ-009 Line counter len_v (10 bit) SHALL:
- count hsync falling edges between vsync falling edges and saturate at 1023;
- compare against 525 at each vsync edge, then restart at 0.
REQ-010 An error event SHALL be any of:
- len_h != 800 at an hsync edge;
- len_v != 525 at a vsync edge;
- len_h reaching 1023, the missing-hsync watchdog, raised once per saturation.
REQ-011 The lock FSM SHALL have states SEARCH, VERIFY and LOCKED, with reset state SEARCH.
REQ-012 In SEARCH, the first vsync falling edge SHALL move the FSM to VERIFY with good=0, and error events SHALL be ignored.
REQ-013 In VERIFY, each vsync falling edge of a frame with no error event SHALL increment good; when good reaches LOCK_FRAMES the FSM SHALL enter LOCKED.
REQ-014 In VERIFY, an error event SHALL return the FSM to SEARCH.
REQ-015 The first vsync edge entering VERIFY SHALL NOT itself be judged, because the frame before it is partial.
REQ-016 In LOCKED, any error event SHALL return the FSM to SEARCH and increment err_cnt, saturating at 255.
REQ-017 locked SHALL be 1 only in state LOCKED, registered, with one CLK of latency from the state change.
REQ-018 video_on SHALL be 1 exactly when locked=1 and pixel_X<640 and pixel_Y<480.
REQ-019 frame_start SHALL pulse for one CLK on the tick where pixel_X and pixel_Y become 0,0 by wrap while locked=1; it SHALL be 0 otherwise.

Reset
REQ-020 While RESET=0, the block SHALL force:
- pixel_X=0, pixel_Y=0;
- video_on=0, locked=0, frame_start=0, err_cnt=0;
- hs_q=1, vs_q=1, len_h=0, len_v=0, good=0;
- FSM=SEARCH.
REQ-021 When RESET deasserts mid-frame, the block SHALL resume from the reset state and require a full relock (first vsync edge plus LOCK_FRAMES clean frames).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Nominal 800x525 timing (hsync low at x 656..751, vsync low at y 490..491) from reset -> locked=1 after the 3rd vsync edge; pixel_X and pixel_Y track the generator exactly; frame_start fires once per 420000 ticks.
- One line shortened to 799 ticks while locked -> locked=0 at the next hsync edge, err_cnt=1, relock after 2 clean frames.
- Hsync held high for 1100 ticks while locked -> watchdog event at len_h=1023, locked=0, err_cnt increments exactly once.
- Hsync and vsync falling on the same tick -> pixel_X=656 and pixel_Y=490 on that tick; video_on=0.
- p_tick gapped (1 in 4 CLK) vs. continuous -> identical pixel_X, pixel_Y and locked sequences per tick.
- RESET pulsed low mid-line -> all outputs 0 immediately; err_cnt forced from 255 to 0; relock timing as in the nominal case.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA timing recovery: rebuilds pixel coordinates from incoming active-low
// H/V sync, qualifies the timing over several frames and reports lock/errors.
module vga_sync_decoder #(
  parameter int HM          = 640,
  parameter int H_DER       = 16,
  parameter int H_RETRAZ    = 96,
  parameter int H_IZQ       = 48,
  parameter int VM          = 480,
  parameter int V_SUP       = 10,
  parameter int V_RETRAZ    = 2,
  parameter int V_INF       = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       p_tick,
  input  logic       sincro_horiz,
  input  logic       sincro_vert,
  output logic [9:0] pixel_X,
  output logic [9:0] pixel_Y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_cnt
);

  localparam int H_TOTAL = HM + H_DER + H_RETRAZ + H_IZQ;
  localparam int V_TOTAL = VM + V_SUP + V_RETRAZ + V_INF;

  localparam logic [9:0] H_ACT     = 10'(HM);
  localparam logic [9:0] V_ACT     = 10'(VM);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LOAD    = 10'(HM + H_DER);
  localparam logic [9:0] V_LOAD    = 10'(VM + V_SUP);
  localparam logic [9:0] H_LEN     = 10'(H_TOTAL);
  localparam logic [9:0] V_LEN     = 10'(V_TOTAL);
  localparam logic [9:0] LEN_MAX   = 10'd1023;
  localparam logic [7:0] GOOD_LAST = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } lock_state_t;

  lock_state_t state;
  logic        hs_q;
  logic        vs_q;
  logic [9:0]  len_h;
  logic [9:0]  len_v;
  logic [7:0]  good;

  logic hs_fall;
  logic vs_fall;
  logic x_wrap;
  logic y_wrap;
  logic h_bad;
  logic v_bad;
  logic watchdog;
  logic err_event;

  assign hs_fall  = hs_q & ~sincro_horiz;
  assign vs_fall  = vs_q & ~sincro_vert;
  // A sync load pre-empts the wrap, so the wrap only exists without a load.
  assign x_wrap   = ~hs_fall && (pixel_X == H_LAST);
  assign y_wrap   = x_wrap && ~vs_fall && (pixel_Y == V_LAST);
  assign h_bad    = hs_fall && (len_h != H_LEN);
  assign v_bad    = vs_fall && (len_v != V_LEN);
  // Fires only on the step into saturation, never while parked at 1023.
  assign watchdog = ~hs_fall && (len_h == LEN_MAX - 10'd1);
  assign err_event = h_bad | v_bad | watchdog;

  assign video_on = locked && (pixel_X < H_ACT) && (pixel_Y < V_ACT);

  // NOTE: non-blocking assignments keep every register reading pre-edge values,
  // so the edge detectors and counters all see the same sampled sync levels.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      pixel_X <= '0;
      pixel_Y <= '0;
      len_h   <= '0;
      len_v   <= '0;
    end else if (p_tick) begin
      hs_q <= sincro_horiz;
      vs_q <= sincro_vert;

      if (hs_fall)     pixel_X <= H_LOAD;
      else if (x_wrap) pixel_X <= '0;
      else             pixel_X <= pixel_X + 10'd1;

      if (vs_fall)     pixel_Y <= V_LOAD;
      else if (x_wrap) pixel_Y <= (pixel_Y == V_LAST) ? 10'd0 : pixel_Y + 10'd1;

      if (hs_fall)               len_h <= 10'd1;
      else if (len_h != LEN_MAX) len_h <= len_h + 10'd1;

      if (vs_fall)                          len_v <= '0;
      else if (hs_fall && len_v != LEN_MAX) len_v <= len_v + 10'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= SEARCH;
      good    <= '0;
      err_cnt <= '0;
    end else if (p_tick) begin
      case (state)
        SEARCH: begin
          // The frame ending at this edge began before we were watching.
          if (vs_fall) begin
            state <= VERIFY;
            good  <= '0;
          end
        end
        VERIFY: begin
          if (err_event) begin
            state <= SEARCH;
          end else if (vs_fall) begin
            good <= good + 8'd1;
            if (good == GOOD_LAST) state <= LOCKED;
          end
        end
        LOCKED: begin
          if (err_event) begin
            state <= SEARCH;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Registered status; runs every CLK so each flag lasts exactly one cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      locked      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      locked      <= (state == LOCKED);
      frame_start <= p_tick && y_wrap && locked;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: a full-size instance for coordinate
// loads/wraps, and a scaled-timing instance (8x6 frame) for lock behaviour.
module tb_vga_sync_decoder;

  localparam int HT  = 8;   // 4 active + 1 front + 2 sync + 1 back
  localparam int VT  = 6;   // 3 active + 1 front + 1 sync + 1 back
  localparam int HS0 = 5;
  localparam int HS1 = 6;
  localparam int VS0 = 4;
  localparam int HA  = 4;
  localparam int VA  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       p_tick = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, fh = 1'b1, fv = 1'b1;
  logic [9:0] px, py, fx, fy;
  logic       von, lck, fs, fvon, flck, ffs;
  logic [7:0] ec, fec;

  vga_sync_decoder #(
    .HM(4), .H_DER(1), .H_RETRAZ(2), .H_IZQ(1),
    .VM(3), .V_SUP(1), .V_RETRAZ(1), .V_INF(1), .LOCK_FRAMES(2)
  ) dut (
    .CLK(clk), .RESET(rst_n), .p_tick(p_tick),
    .sincro_horiz(hs), .sincro_vert(vs),
    .pixel_X(px), .pixel_Y(py), .video_on(von), .locked(lck),
    .frame_start(fs), .err_cnt(ec)
  );

  vga_sync_decoder dut_full (
    .CLK(clk), .RESET(rst_n), .p_tick(p_tick),
    .sincro_horiz(fh), .sincro_vert(fv),
    .pixel_X(fx), .pixel_Y(fy), .video_on(fvon), .locked(flck),
    .frame_start(ffs), .err_cnt(fec)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int gx = 0, gy = 0;
  int gap = 0;
  bit short_pending = 1'b0;
  bit track_en = 1'b0;
  int lock_mode = 0;       // 0 none, 1 expect unlocked, 2 expect locked
  int rec_mode = 0;        // 0 none, 1 record, 2 compare to record
  int rec_idx = 0;
  int rec_err = 0;
  int track_err = 0;
  int fs_cnt = 0;
  int vs_seen = 0;
  int lock_to = 0;
  logic [20:0] rec_c [200];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel of the scaled generator, then any idle CLKs for gapped mode.
  task automatic pix();
    logic [20:0] cur;
    @(negedge clk);
    hs = !(gx >= HS0 && gx <= HS1);
    vs = !(gy == VS0);
    p_tick = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    if (gx == 0 && gy == VS0) vs_seen++;
    if (track_en && (px !== 10'(gx) || py !== 10'(gy))) track_err++;
    if (fs === 1'b1) fs_cnt++;
    if (lock_mode == 1 && (lck !== 1'b0 || von !== 1'b0 || fs !== 1'b0)) track_err++;
    if (lock_mode == 2) begin
      if (lck !== 1'b1) track_err++;
      if (von !== (gx < HA && gy < VA)) track_err++;
      if (fs !== (gx == 0 && gy == 0)) track_err++;
    end
    cur = {lck, px, py};
    if (rec_idx < 200) begin
      if (rec_mode == 1) rec_c[rec_idx] = cur;
      if (rec_mode == 2 && rec_c[rec_idx] !== cur) rec_err++;
      rec_idx++;
    end
    if (short_pending && gx == HT - 2) begin
      short_pending = 1'b0;
      gx = 0;
      gy = (gy + 1) % VT;
    end else if (gx == HT - 1) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end else begin
      gx++;
    end
    repeat (gap) @(posedge clk);
  endtask

  // Ticks with both syncs held high, generator frozen.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = 1'b1;
      vs = 1'b1;
      p_tick = 1'b1;
      @(posedge clk);
      #1;
      p_tick = 1'b0;
    end
  endtask

  task automatic ftick(input logic h, input logic v);
    @(negedge clk);
    fh = h;
    fv = v;
    p_tick = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
  endtask

  task automatic run_until_vs(input int n);
    int start = vs_seen;
    int k = 0;
    while (vs_seen - start < n && k < 400) begin
      pix();
      k++;
    end
    check("vs_edges_reached", vs_seen - start, n);
  endtask

  task automatic goto_origin();
    int k = 0;
    while (!(gx == 0 && gy == 0) && k < 60) begin
      pix();
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gx = 0;
    gy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Relock if needed, then shorten line 0; the error lands 13 ticks later.
  task automatic lose_lock();
    int k = 0;
    while (lck !== 1'b1 && k < 400) begin
      pix();
      k++;
    end
    if (lck !== 1'b1) lock_to++;
    goto_origin();
    short_pending = 1'b1;
    repeat (14) pix();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_x", px, 0);
    check("rst_y", py, 0);
    check("rst_video_on", von, 0);
    check("rst_locked", lck, 0);
    check("rst_frame_start", fs, 0);
    check("rst_err_cnt", ec, 0);
    check("rst_full_x", fx, 0);
    check("rst_full_y", fy, 0);
    check("rst_full_locked", flck, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-size timing: coincident sync edges, then X wrap drives Y.
    ftick(1'b1, 1'b1);
    ftick(1'b1, 1'b1);
    ftick(1'b0, 1'b0);
    check("same_tick_x", fx, 656);
    check("same_tick_y", fy, 490);
    check("same_tick_video_on", fvon, 0);
    ftick(1'b0, 1'b0);
    check("after_load_x", fx, 657);
    check("after_load_y", fy, 490);
    for (int i = 0; i < 142; i++) ftick(1'b1, 1'b1);
    check("x_last", fx, 799);
    ftick(1'b1, 1'b1);
    check("x_wrap_x", fx, 0);
    check("x_wrap_y", fy, 491);

    // Nominal lock from reset: LOCKED on the 3rd vsync edge, flag a CLK later.
    do_reset();
    lock_mode = 1;
    run_until_vs(1);
    track_en = 1'b1;
    run_until_vs(2);
    check("nom_locked_pre", lck, 0);
    lock_mode = 0;
    pix();
    check("nom_locked", lck, 1);
    lock_mode = 2;
    fs_cnt = 0;
    repeat (3 * HT * VT) pix();
    check("nom_frame_starts", fs_cnt, 3);
    check("nom_track_errors", track_err, 0);
    lock_mode = 0;
    track_en = 1'b0;

    // Continuous versus 1-in-4 gapped ticks from reset.
    do_reset();
    rec_mode = 1;
    rec_idx = 0;
    repeat (200) pix();
    do_reset();
    gap = 3;
    rec_mode = 2;
    rec_idx = 0;
    repeat (200) pix();
    gap = 0;
    rec_mode = 0;
    check("gapped_seq_mismatches", rec_err, 0);
    check("gapped_locked", lck, 1);

    // Short line while locked.
    goto_origin();
    short_pending = 1'b1;
    repeat (12) pix();
    check("short_err_before", ec, 0);
    pix();
    check("short_err_at_edge", ec, 1);
    pix();
    check("short_locked_drop", lck, 0);
    run_until_vs(3);
    check("short_relock_pre", lck, 0);
    pix();
    check("short_relock", lck, 1);

    // Missing hsync: len_h is 3 at the origin, saturates after 1020 held ticks.
    goto_origin();
    hold(1019);
    check("wdog_err_before", ec, 1);
    hold(1);
    check("wdog_err_at_sat", ec, 2);
    hold(80);
    check("wdog_locked_drop", lck, 0);
    check("wdog_err_once", ec, 2);
    run_until_vs(3);
    check("wdog_relock_pre", lck, 0);
    pix();
    check("wdog_relock", lck, 1);
    check("wdog_err_after_relock", ec, 2);

    // Drive the error counter into saturation.
    for (int i = 0; i < 253; i++) lose_lock();
    check("err_cnt_255", ec, 255);
    lose_lock();
    check("err_cnt_saturated", ec, 255);
    check("relock_timeouts", lock_to, 0);

    // Asynchronous reset mid-line, then a full relock.
    begin
      int k = 0;
      while (!(gx == 2 && gy == 1) && k < 60) begin
        pix();
        k++;
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_x", px, 0);
    check("mid_rst_y", py, 0);
    check("mid_rst_video_on", von, 0);
    check("mid_rst_locked", lck, 0);
    check("mid_rst_frame_start", fs, 0);
    check("mid_rst_err_cnt", ec, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    track_err = 0;
    lock_mode = 1;
    run_until_vs(3);
    check("mid_rst_relock_pre", lck, 0);
    lock_mode = 0;
    pix();
    check("mid_rst_relock", lck, 1);
    check("mid_rst_no_early_lock", track_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
